// File: rtl/frame_pkg.sv
// Shared types and widths for the frame scheduler and the drawing layers.
package frame_pkg;
   localparam int COORD_W = 10;
   localparam int COLOR_W = 8;
   localparam int TMO_W   = 20;
   localparam logic [1:0] FRAME_EDGE_RISE = 2'b01;

   typedef enum logic [2:0] {IDLE, START, RUN, WAIT_SWAP, SWAP} state_t;
endpackage

// File: rtl/layer_mux.sv
// N-way select of the per-layer pixel write port onto the frame-buffer port.
module layer_mux
   import frame_pkg::*;
#(
   parameter int N_LAYERS = 4,
   parameter int SEL_W    = 2
)(
   input  logic                               en,
   input  logic [SEL_W-1:0]                   sel,
   input  logic [N_LAYERS-1:0]                wr_req,
   input  logic [N_LAYERS-1:0][COORD_W-1:0]   x,
   input  logic [N_LAYERS-1:0][COORD_W-1:0]   y,
   input  logic [N_LAYERS-1:0][COLOR_W-1:0]   color,
   output logic                               fb_wr_en,
   output logic [COORD_W-1:0]                 fb_x,
   output logic [COORD_W-1:0]                 fb_y,
   output logic [COLOR_W-1:0]                 fb_color
);
   // Compare against every index so a non-power-of-two layer count never reads out of range.
   always_comb begin
      fb_wr_en = 1'b0;
      fb_x     = '0;
      fb_y     = '0;
      fb_color = '0;
      if (en) begin
         for (int i = 0; i < N_LAYERS; i++) begin
            if (sel == SEL_W'(i)) begin
               fb_wr_en = wr_req[i];
               fb_x     = x[i];
               fb_y     = y[i];
               fb_color = color[i];
            end
         end
      end
   end
endmodule

// File: rtl/frame_sched.sv
// Per-frame layer sequencer with double-buffer swap on vblank.
// Optional overrun counter enabled by FRAME_SCHED_OVERRUN_CNT_EN.
module frame_sched
   import frame_pkg::*;
#(
   parameter int               N_LAYERS      = 4,
   parameter logic [TMO_W-1:0] LAYER_TIMEOUT = 20'd400000
)(
   input  logic                               Clk,
   input  logic                               Reset,
   input  logic [1:0]                         frame_clk_edge,
   input  logic                               vblank,
   input  logic [N_LAYERS-1:0]                layer_done,
   input  logic [N_LAYERS-1:0]                layer_wr_req,
   input  logic [N_LAYERS-1:0][COORD_W-1:0]   layer_x,
   input  logic [N_LAYERS-1:0][COORD_W-1:0]   layer_y,
   input  logic [N_LAYERS-1:0][COLOR_W-1:0]   layer_color,
   output logic [N_LAYERS-1:0]                layer_start,
   output logic                               fb_wr_en,
   output logic [COORD_W-1:0]                 fb_x,
   output logic [COORD_W-1:0]                 fb_y,
   output logic [COLOR_W-1:0]                 fb_color,
   output logic                               buffer_using,
   output logic                               frame_busy,
   output logic [7:0]                         overrun_cnt
);
   localparam int CW = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;

   state_t           state, state_nx;
   logic [CW-1:0]    cur;
   logic [TMO_W-1:0] tmo;
   logic             rise, last, run_end;

   assign rise       = (frame_clk_edge == FRAME_EDGE_RISE);
   assign last       = (cur == CW'(N_LAYERS - 1));
   assign run_end    = layer_done[cur] || (tmo == LAYER_TIMEOUT - TMO_W'(1));
   assign frame_busy = (state != IDLE);

   always_comb begin
      state_nx    = state;
      layer_start = '0;
      case (state)
         IDLE:      if (rise) state_nx = START;
         START: begin
            layer_start[cur] = 1'b1;
            state_nx         = RUN;
         end
         RUN:       if (run_end) state_nx = last ? WAIT_SWAP : START;
         WAIT_SWAP: if (vblank) state_nx = SWAP;
         SWAP:      state_nx = IDLE;
         default:   state_nx = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state        <= IDLE;
         cur          <= '0;
         tmo          <= '0;
         buffer_using <= 1'b0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE:  if (rise) cur <= '0;
            START: tmo <= '0;
            RUN: begin
               if (tmo != '1) tmo <= tmo + TMO_W'(1);
               if (run_end && !last) cur <= cur + CW'(1);
            end
            // Toggle on entry so the SWAP cycle already shows the new display buffer.
            WAIT_SWAP: if (vblank) buffer_using <= ~buffer_using;
            default: ;
         endcase
      end
   end

`ifdef FRAME_SCHED_OVERRUN_CNT_EN
   always_ff @(posedge Clk) begin
      if (Reset)
         overrun_cnt <= '0;
      else if (frame_busy && rise && overrun_cnt != 8'hFF)
         overrun_cnt <= overrun_cnt + 8'd1;
   end
`else
   assign overrun_cnt = '0;
`endif

   layer_mux #(.N_LAYERS(N_LAYERS), .SEL_W(CW)) u_mux (
      .en       (state == RUN),
      .sel      (cur),
      .wr_req   (layer_wr_req),
      .x        (layer_x),
      .y        (layer_y),
      .color    (layer_color),
      .fb_wr_en (fb_wr_en),
      .fb_x     (fb_x),
      .fb_y     (fb_y),
      .fb_color (fb_color)
   );
endmodule

// File: tb/tb_frame_sched.sv
// Bench for frame_sched: frame-level reference model, directed scenarios, then random traffic.
module tb_frame_sched;
   import frame_pkg::*;
   localparam int N   = 4;
   localparam int TMO = 16;
`ifdef FRAME_SCHED_OVERRUN_CNT_EN
   localparam bit OV_EN = 1'b1;
`else
   localparam bit OV_EN = 1'b0;
`endif

   logic Clk = 1'b0;
   logic Reset;
   logic [1:0] frame_clk_edge;
   logic vblank;
   logic [N-1:0] layer_done, layer_wr_req, layer_start;
   logic [N-1:0][COORD_W-1:0] layer_x, layer_y;
   logic [N-1:0][COLOR_W-1:0] layer_color;
   logic fb_wr_en, buffer_using, frame_busy;
   logic [COORD_W-1:0] fb_x, fb_y;
   logic [COLOR_W-1:0] fb_color;
   logic [7:0] overrun_cnt;

   frame_sched #(.N_LAYERS(N), .LAYER_TIMEOUT(20'(TMO))) dut (
      .Clk(Clk), .Reset(Reset), .frame_clk_edge(frame_clk_edge), .vblank(vblank),
      .layer_done(layer_done), .layer_wr_req(layer_wr_req), .layer_x(layer_x),
      .layer_y(layer_y), .layer_color(layer_color), .layer_start(layer_start),
      .fb_wr_en(fb_wr_en), .fb_x(fb_x), .fb_y(fb_y), .fb_color(fb_color),
      .buffer_using(buffer_using), .frame_busy(frame_busy), .overrun_cnt(overrun_cnt)
   );

   always #5 Clk = ~Clk;

   int checks = 0, errors = 0;
   bit armed = 1'b0;
   int cyc = 0;

   // Model: stage 0 idle, 1 start pulse, 2 layer drawing, 3 waiting for vblank, 4 swap.
   int m_stage = 0, m_layer = 0, m_elapsed = 0, m_ov = 0;
   bit m_buf = 1'b0;

   int n_wr = 0, n_toggle = 0, toggle_cyc = 0;
   int start_log[$];
   int start_cyc[N];
   logic prev_buf = 1'b0;

   logic [N-1:0] e_start;
   logic e_wr;
   logic [COORD_W-1:0] e_x, e_y;
   logic [COLOR_W-1:0] e_c;
   logic [7:0] e_ov;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   initial forever begin
      @(posedge Clk);
      cyc++;
      if (Reset) begin
         m_stage = 0; m_layer = 0; m_elapsed = 0; m_buf = 1'b0; m_ov = 0;
      end else begin
         if (m_stage != 0 && frame_clk_edge == 2'b01 && m_ov < 255) m_ov++;
         case (m_stage)
            0: if (frame_clk_edge == 2'b01) begin m_stage = 1; m_layer = 0; end
            1: begin m_stage = 2; m_elapsed = 0; end
            2: if (layer_done[m_layer] || m_elapsed == TMO - 1) begin
                  if (m_layer == N - 1) m_stage = 3;
                  else begin m_layer++; m_stage = 1; end
               end else m_elapsed++;
            3: if (vblank) begin m_stage = 4; m_buf = !m_buf; end
            default: m_stage = 0;
         endcase
      end
   end

   initial forever begin
      @(negedge Clk);
      if (armed && !Reset) begin
         e_start = (m_stage == 1) ? N'(1) << m_layer : '0;
         e_wr    = (m_stage == 2) && layer_wr_req[m_layer];
         e_x     = (m_stage == 2) ? layer_x[m_layer] : '0;
         e_y     = (m_stage == 2) ? layer_y[m_layer] : '0;
         e_c     = (m_stage == 2) ? layer_color[m_layer] : '0;
         e_ov    = OV_EN ? 8'(m_ov) : 8'd0;
         chk("layer_start", 32'(layer_start), 32'(e_start));
         chk("fb_wr_en", 32'(fb_wr_en), 32'(e_wr));
         chk("fb_x", 32'(fb_x), 32'(e_x));
         chk("fb_y", 32'(fb_y), 32'(e_y));
         chk("fb_color", 32'(fb_color), 32'(e_c));
         chk("frame_busy", 32'(frame_busy), 32'(m_stage != 0));
         chk("buffer_using", 32'(buffer_using), 32'(m_buf));
         chk("overrun_cnt", 32'(overrun_cnt), 32'(e_ov));
         n_wr += int'(fb_wr_en);
         for (int j = 0; j < N; j++)
            if (layer_start[j]) begin start_log.push_back(j); start_cyc[j] = cyc; end
         if (buffer_using !== prev_buf) begin n_toggle++; toggle_cyc = cyc; end
         prev_buf = buffer_using;
      end
   end

   task automatic clear_layers();
      layer_done = '0; layer_wr_req = '0; layer_x = '0; layer_y = '0; layer_color = '0;
   endtask

   task automatic wait_start(input int L);
      bit got = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge Clk);
         if (layer_start[L]) got = 1'b1;
      end
      if (!got) begin
         checks++; errors++;
         $display("FAIL wait_start layer %0d timed out", L);
      end
   endtask

   // Layer L draws nwr pixels after its start pulse; other layers emit noise that must be ignored.
   task automatic run_layer(input int L, input int nwr, input bit give_done);
      wait_start(L);
      for (int k = 0; k < nwr; k++) begin
         @(posedge Clk); #1;
         for (int j = 0; j < N; j++) begin
            layer_x[j] = COORD_W'($urandom); layer_y[j] = COORD_W'($urandom);
            layer_color[j] = COLOR_W'($urandom);
            layer_wr_req[j] = (j == L) ? 1'b1 : 1'($urandom);
            layer_done[j] = (j == L) ? (give_done && k == nwr - 1) : 1'($urandom);
         end
      end
      @(posedge Clk); #1;
      clear_layers();
   endtask

   task automatic pulse_edge();
      @(posedge Clk); #1 frame_clk_edge = 2'b01;
      @(posedge Clk); #1 frame_clk_edge = 2'b00;
   endtask

   int b_wr, b_st, b_tg, rise_cyc;

   initial begin
      Reset = 1'b1; frame_clk_edge = 2'b00; vblank = 1'b0;
      clear_layers();
      repeat (3) @(posedge Clk);
      #1 Reset = 1'b0; armed = 1'b1;
      @(negedge Clk);
      chk("rst_busy", 32'(frame_busy), 0);
      chk("rst_buf", 32'(buffer_using), 0);
      chk("rst_ov", 32'(overrun_cnt), 0);
      chk("rst_start", 32'(layer_start), 0);

      // Frame 1: every layer draws 3 pixels, vblank already high.
      vblank = 1'b1;
      b_wr = n_wr; b_st = start_log.size(); b_tg = n_toggle;
      pulse_edge();
      for (int L = 0; L < N; L++) run_layer(L, 3, 1'b1);
      repeat (4) @(negedge Clk);
      chk("f1_writes", 32'(n_wr - b_wr), 12);
      chk("f1_nstarts", 32'(start_log.size() - b_st), 4);
      for (int i = 0; i < N; i++) chk("f1_order", 32'(start_log[b_st + i]), 32'(i));
      chk("f1_toggles", 32'(n_toggle - b_tg), 1);
      chk("f1_buf", 32'(buffer_using), 1);
      chk("f1_idle", 32'(frame_busy), 0);

      // Frame 2: layer 1 times out, three edges arrive mid-frame, vblank late.
      vblank = 1'b0;
      b_st = start_log.size();
      pulse_edge();
      run_layer(0, 3, 1'b1);
      run_layer(1, 2, 1'b0);
      repeat (3) pulse_edge();
      run_layer(2, 3, 1'b1);
      chk("tmo_gap", 32'(start_cyc[2] - start_cyc[1]), 17);
      chk("ov_mid", 32'(overrun_cnt), OV_EN ? 3 : 0);
      chk("no_restart", 32'(start_log.size() - b_st), 3);
      run_layer(3, 3, 1'b1);
      b_wr = n_wr;
      repeat (50) begin
         @(negedge Clk);
         chk("wait_busy", 32'(frame_busy), 1);
      end
      chk("wait_nowr", 32'(n_wr - b_wr), 0);
      @(posedge Clk); #1 vblank = 1'b1; rise_cyc = cyc;
      repeat (3) @(negedge Clk);
      chk("swap_cycle", 32'(toggle_cyc - rise_cyc), 1);
      chk("f2_buf", 32'(buffer_using), 0);
      chk("f2_idle", 32'(frame_busy), 0);

      // Frame 3: foreign layer activity during layer 0, then reset while layer 2 runs.
      pulse_edge();
      wait_start(0);
      @(posedge Clk); #1 layer_wr_req = 4'b0100; layer_done = 4'b0100; layer_x[2] = 10'd77;
      @(negedge Clk);
      chk("iso_wr", 32'(fb_wr_en), 0);
      @(posedge Clk); #1 clear_layers();
      @(negedge Clk);
      chk("iso_busy", 32'(frame_busy), 1);
      chk("iso_nostart", 32'(layer_start), 0);
      @(posedge Clk); #1 layer_done[0] = 1'b1;
      @(posedge Clk); #1 clear_layers();
      run_layer(1, 3, 1'b1);
      wait_start(2);
      @(posedge Clk); #1 layer_wr_req[2] = 1'b1;
      @(posedge Clk); #1 Reset = 1'b1; layer_wr_req = '0;
      @(posedge Clk); #1 Reset = 1'b0;
      @(negedge Clk);
      chk("rr_busy", 32'(frame_busy), 0);
      chk("rr_wr", 32'(fb_wr_en), 0);
      chk("rr_buf", 32'(buffer_using), 0);
      chk("rr_ov", 32'(overrun_cnt), 0);
      prev_buf = buffer_using;

      // Frame 4: fresh frame after reset; edges hammered while waiting to saturate the counter.
      b_st = start_log.size();
      vblank = 1'b0;
      pulse_edge();
      for (int L = 0; L < N; L++) run_layer(L, 2, 1'b1);
      repeat (300) pulse_edge();
      chk("ov_sat", 32'(overrun_cnt), OV_EN ? 255 : 0);
      @(posedge Clk); #1 vblank = 1'b1;
      repeat (3) @(negedge Clk);
      chk("f4_nstarts", 32'(start_log.size() - b_st), 4);
      chk("f4_buf", 32'(buffer_using), 1);

      // Random traffic checked only by the model.
      repeat (3000) begin
         @(posedge Clk); #1;
         Reset = ($urandom_range(0, 999) == 0);
         frame_clk_edge = ($urandom_range(0, 7) == 0) ? 2'b01 : 2'($urandom);
         vblank = ($urandom_range(0, 3) == 0);
         for (int j = 0; j < N; j++) begin
            layer_wr_req[j] = 1'($urandom);
            layer_done[j] = ($urandom_range(0, 5) == 0);
            layer_x[j] = COORD_W'($urandom); layer_y[j] = COORD_W'($urandom);
            layer_color[j] = COLOR_W'($urandom);
         end
      end
      @(posedge Clk); #1 Reset = 1'b0; clear_layers();
      @(negedge Clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
